color_threshold_tracker: RTL and testbench
==========================================

# color_threshold_tracker

Parametrised streaming colour-threshold stage for the camera path. It classifies each RGB565 pixel against runtime-programmable per-channel min/max windows and re-colours the pixel according to a selectable display mode. It also accumulates per-frame blob statistics: match count and bounding box. It sits between the camera pixel interface and the frame-buffer writer, and is configured by the CPU through a small register write port.

## Interface
- `X_WIDTH`, 11, width of column counter and bbox X outputs
- `Y_WIDTH`, 10, width of row counter and bbox Y outputs
- `COUNT_WIDTH`, 20, width of matched-pixel counter
- `MARK_COLOR`, 16'h07E0, RGB565 colour used for matched pixels in modes 1/2

- `clock` in 1, single clock for the whole block
- `reset` in 1, asynchronous, active-high
- `pixelIn` in 16, RGB565 pixel: R=[15:11], G=[10:5], B=[4:0]
- `pixelValidIn` in 1, pixelIn valid this cycle; no back-pressure
- `newLine` in 1, qualified by pixelValidIn; marks first pixel of a line
- `newScreen` in 1, qualified by pixelValidIn; marks first pixel of a frame (implies newLine)
- `cfgWe` in 1, configuration write strobe
- `cfgAddr` in 2, 0=minThr, 1=maxThr, 2=mode[1:0]
- `cfgData` in 16, write data, RGB565-packed for addr 0/1
- `pixelOut` out 16, processed pixel
- `pixelValidOut` out 1, pixelOut valid
- `matchOut` out 1, pixel on pixelOut met the threshold
- `matchCount` out COUNT_WIDTH, matched pixels in last completed frame
- `bboxXMin`, `bboxXMax` out X_WIDTH; `bboxYMin`, `bboxYMax` out Y_WIDTH, bounding box of last completed frame
- `statsValid` out 1, one-cycle pulse when stats outputs update

## Operation
- Config registers reset: minThr=16'hC018 (R24,G0,B24), maxThr=16'hF9FF (R31,G15,B31), mode=1. Write with cfgWe; the value applies to pixels accepted on the following cycles. No shadowing; mid-frame writes act immediately.
- Match: for each channel, min ≤ c ≤ max, unsigned, inclusive; all three channels must pass. If min>max for any channel, nothing matches.
- Modes:
  - 0: pass-through, pixelOut=pixelIn
  - 1: highlight, matched→MARK_COLOR, otherwise pixelIn
  - 2: binary, matched→MARK_COLOR, otherwise 0
  - 3: cutout, matched→pixelIn, otherwise 0
  - matchOut and the stats are computed in every mode.
- Position counters track valid pixels.
  - x: set to 0 on newLine or newScreen, otherwise +1 per valid pixel; saturates at all-ones.
  - y: set to 0 on newScreen, +1 on newLine without newScreen; saturates at all-ones.
- Accumulators:
  - count: +1 per matched valid pixel; saturates at all-ones.
  - xMin/yMin: start all-ones, keep the minimum.
  - xMax/yMax: start 0, keep the maximum.
- Frame close: when a valid pixel with newScreen reaches stage 2:
  - if frameSeen=1, copy accumulators to the stats outputs and pulse statsValid;
  - reinitialise accumulators, then include the current pixel;
  - set frameSeen=1.
- The first newScreen after reset produces no statsValid.
- Empty frame: matchCount=0 and bbox outputs show min=all-ones, max=0. Consumers detect emptiness by xMin>xMax.

## Timing
- 2-stage pipeline:
  - Stage 1 registers the pixel, x/y, line/screen flags and the three channel compares.
  - Stage 2 performs the mode mux, accumulator update and output register.
- Latency: pixelValidIn at cycle N → pixelValidOut at N+2. Throughput is 1 pixel/cycle; bubbles propagate unchanged.
- statsValid rises in the same cycle as pixelValidOut for the newScreen pixel. Stats outputs change only in that cycle and hold otherwise.
- Config write in cycle N affects a pixel accepted in cycle N+1 or later. A pixel accepted in cycle N uses the old value.
- Reset (asynchronous, any time, including mid-frame):
  - pixelOut=0, pixelValidOut=0, matchOut=0, statsValid=0;
  - matchCount=0, bboxXMin/YMin=all-ones, bboxXMax/YMax=0;
  - pipeline valids, counters and accumulators cleared, frameSeen=0;
  - config registers return to their defaults.
- newLine/newScreen are ignored when pixelValidIn=0.

## Test plan
- Reset defaults, mode 1: pixel F81F → pixelOut 07E0, matchOut 1, exactly 2 cycles later; pixel 001F → 001F, matchOut 0.
- Mode sweep on pixel F81F, then 1234:
  - mode 0: F81F, 1234
  - mode 2: 07E0, 0000
  - mode 3: F81F, 0000
- Boundary compares: minThr=maxThr=F81F; F81F matches; F81E (B-1) and F83F (G+1) do not. minThr=FFFF, maxThr=0 → no match.
- Two 8×4 frames with matches at (2,1), (5,3), (3,2), second frame with no matches:
  - first newScreen: no pulse;
  - second newScreen: statsValid, count=3, X 2..5, Y 1..3;
  - third newScreen: count=0, xMin=7FF, xMax=0.
- Mid-stream cfg write of maxThr=0 between back-to-back valid pixels: the pixel accepted in the write cycle uses the old threshold, the next pixel the new one. Random pixelValidIn gaps preserve the 2-cycle latency.
- Assert reset mid-frame after 10 matches: all outputs return to reset values immediately; the next newScreen produces no statsValid.

Source files
------------

// File: rtl/color_threshold_tracker.sv
// rtl/color_threshold_tracker.sv - RGB565 colour-threshold classifier with per-frame match count and bounding box
module color_threshold_tracker #(
    parameter int          X_WIDTH     = 11,
    parameter int          Y_WIDTH     = 10,
    parameter int          COUNT_WIDTH = 20,
    parameter logic [15:0] MARK_COLOR  = 16'h07E0
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [15:0]            pixelIn,
    input  logic                   pixelValidIn,
    input  logic                   newLine,
    input  logic                   newScreen,
    input  logic                   cfgWe,
    input  logic [1:0]             cfgAddr,
    input  logic [15:0]            cfgData,
    output logic [15:0]            pixelOut,
    output logic                   pixelValidOut,
    output logic                   matchOut,
    output logic [COUNT_WIDTH-1:0] matchCount,
    output logic [X_WIDTH-1:0]     bboxXMin,
    output logic [X_WIDTH-1:0]     bboxXMax,
    output logic [Y_WIDTH-1:0]     bboxYMin,
    output logic [Y_WIDTH-1:0]     bboxYMax,
    output logic                   statsValid
);
    localparam logic [15:0]            MIN_RST = 16'hC018;
    localparam logic [15:0]            MAX_RST = 16'hF9FF;
    localparam logic [X_WIDTH-1:0]     X_ONES  = '1;
    localparam logic [Y_WIDTH-1:0]     Y_ONES  = '1;
    localparam logic [COUNT_WIDTH-1:0] C_ONES  = '1;

    logic [15:0] min_thr_q, max_thr_q;
    logic [1:0]  mode_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            min_thr_q <= MIN_RST;
            max_thr_q <= MAX_RST;
            mode_q    <= 2'd1;
        end else if (cfgWe) begin
            case (cfgAddr)
                2'd0:    min_thr_q <= cfgData;
                2'd1:    max_thr_q <= cfgData;
                2'd2:    mode_q    <= cfgData[1:0];
                default: ;
            endcase
        end
    end

    // Stage 1: position of the incoming pixel and channel window compares
    logic [X_WIDTH-1:0] pos_x_q, x_cur;
    logic [Y_WIDTH-1:0] pos_y_q, y_cur;
    logic [2:0]         pass_cur;

    always_comb begin
        x_cur = (pos_x_q == X_ONES) ? pos_x_q : pos_x_q + 1'b1;
        if (newLine || newScreen) x_cur = '0;
        y_cur = pos_y_q;
        if (newScreen)                      y_cur = '0;
        else if (newLine && pos_y_q != Y_ONES) y_cur = pos_y_q + 1'b1;
        pass_cur[2] = (pixelIn[15:11] >= min_thr_q[15:11]) && (pixelIn[15:11] <= max_thr_q[15:11]);
        pass_cur[1] = (pixelIn[10:5]  >= min_thr_q[10:5])  && (pixelIn[10:5]  <= max_thr_q[10:5]);
        pass_cur[0] = (pixelIn[4:0]   >= min_thr_q[4:0])   && (pixelIn[4:0]   <= max_thr_q[4:0]);
    end

    logic               s1_valid_q, s1_screen_q;
    logic [15:0]        s1_pixel_q;
    logic [X_WIDTH-1:0] s1_x_q;
    logic [Y_WIDTH-1:0] s1_y_q;
    logic [2:0]         s1_pass_q;
    logic [1:0]         s1_mode_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pos_x_q     <= '0;
            pos_y_q     <= '0;
            s1_valid_q  <= 1'b0;
            s1_screen_q <= 1'b0;
            s1_pixel_q  <= '0;
            s1_x_q      <= '0;
            s1_y_q      <= '0;
            s1_pass_q   <= '0;
            s1_mode_q   <= 2'd1;
        end else begin
            s1_valid_q <= pixelValidIn;
            if (pixelValidIn) begin
                pos_x_q     <= x_cur;
                pos_y_q     <= y_cur;
                s1_screen_q <= newScreen;
                s1_pixel_q  <= pixelIn;
                s1_x_q      <= x_cur;
                s1_y_q      <= y_cur;
                s1_pass_q   <= pass_cur;
                s1_mode_q   <= mode_q;
            end
        end
    end

    // Stage 2: recolour, accumulate, and publish stats on frame close
    logic                   hit, close;
    logic [15:0]            pixel_d;
    logic                   seen_q, seen_d, stats_valid_d;
    logic [COUNT_WIDTH-1:0] acc_cnt_q, acc_cnt_d, st_cnt_q, st_cnt_d;
    logic [X_WIDTH-1:0]     acc_xmin_q, acc_xmin_d, acc_xmax_q, acc_xmax_d;
    logic [X_WIDTH-1:0]     st_xmin_q, st_xmin_d, st_xmax_q, st_xmax_d;
    logic [Y_WIDTH-1:0]     acc_ymin_q, acc_ymin_d, acc_ymax_q, acc_ymax_d;
    logic [Y_WIDTH-1:0]     st_ymin_q, st_ymin_d, st_ymax_q, st_ymax_d;

    always_comb begin
        hit   = s1_valid_q && (&s1_pass_q);
        close = s1_valid_q && s1_screen_q;
        case (s1_mode_q)
            2'd0:    pixel_d = s1_pixel_q;
            2'd1:    pixel_d = hit ? MARK_COLOR : s1_pixel_q;
            2'd2:    pixel_d = hit ? MARK_COLOR : 16'h0000;
            default: pixel_d = hit ? s1_pixel_q : 16'h0000;
        endcase
        seen_d        = seen_q;
        stats_valid_d = 1'b0;
        acc_cnt_d     = acc_cnt_q;
        acc_xmin_d    = acc_xmin_q;
        acc_xmax_d    = acc_xmax_q;
        acc_ymin_d    = acc_ymin_q;
        acc_ymax_d    = acc_ymax_q;
        st_cnt_d      = st_cnt_q;
        st_xmin_d     = st_xmin_q;
        st_xmax_d     = st_xmax_q;
        st_ymin_d     = st_ymin_q;
        st_ymax_d     = st_ymax_q;
        if (close) begin
            if (seen_q) begin
                st_cnt_d      = acc_cnt_q;
                st_xmin_d     = acc_xmin_q;
                st_xmax_d     = acc_xmax_q;
                st_ymin_d     = acc_ymin_q;
                st_ymax_d     = acc_ymax_q;
                stats_valid_d = 1'b1;
            end
            seen_d     = 1'b1;
            acc_cnt_d  = '0;
            acc_xmin_d = X_ONES;
            acc_xmax_d = '0;
            acc_ymin_d = Y_ONES;
            acc_ymax_d = '0;
        end
        if (hit) begin
            if (acc_cnt_d != C_ONES)   acc_cnt_d  = acc_cnt_d + 1'b1;
            if (s1_x_q < acc_xmin_d)   acc_xmin_d = s1_x_q;
            if (s1_x_q > acc_xmax_d)   acc_xmax_d = s1_x_q;
            if (s1_y_q < acc_ymin_d)   acc_ymin_d = s1_y_q;
            if (s1_y_q > acc_ymax_d)   acc_ymax_d = s1_y_q;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pixelOut      <= '0;
            pixelValidOut <= 1'b0;
            matchOut      <= 1'b0;
            statsValid    <= 1'b0;
            seen_q        <= 1'b0;
            acc_cnt_q     <= '0;
            acc_xmin_q    <= X_ONES;
            acc_xmax_q    <= '0;
            acc_ymin_q    <= Y_ONES;
            acc_ymax_q    <= '0;
            st_cnt_q      <= '0;
            st_xmin_q     <= X_ONES;
            st_xmax_q     <= '0;
            st_ymin_q     <= Y_ONES;
            st_ymax_q     <= '0;
        end else begin
            pixelOut      <= pixel_d;
            pixelValidOut <= s1_valid_q;
            matchOut      <= hit;
            statsValid    <= stats_valid_d;
            seen_q        <= seen_d;
            acc_cnt_q     <= acc_cnt_d;
            acc_xmin_q    <= acc_xmin_d;
            acc_xmax_q    <= acc_xmax_d;
            acc_ymin_q    <= acc_ymin_d;
            acc_ymax_q    <= acc_ymax_d;
            st_cnt_q      <= st_cnt_d;
            st_xmin_q     <= st_xmin_d;
            st_xmax_q     <= st_xmax_d;
            st_ymin_q     <= st_ymin_d;
            st_ymax_q     <= st_ymax_d;
        end
    end

    assign matchCount = st_cnt_q;
    assign bboxXMin   = st_xmin_q;
    assign bboxXMax   = st_xmax_q;
    assign bboxYMin   = st_ymin_q;
    assign bboxYMax   = st_ymax_q;
endmodule

// File: tb/tb_color_threshold_tracker.sv
// tb/tb_color_threshold_tracker.sv - randomized and directed bench for color_threshold_tracker against a frame-level model
module tb_color_threshold_tracker;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] pixelIn = '0;
    logic        pixelValidIn = 1'b0, newLine = 1'b0, newScreen = 1'b0;
    logic        cfgWe = 1'b0;
    logic [1:0]  cfgAddr = '0;
    logic [15:0] cfgData = '0;
    logic [15:0] pixelOut;
    logic        pixelValidOut, matchOut, statsValid;
    logic [19:0] matchCount;
    logic [10:0] bboxXMin, bboxXMax;
    logic [9:0]  bboxYMin, bboxYMax;

    color_threshold_tracker dut (
        .clock(clock), .reset(reset), .pixelIn(pixelIn), .pixelValidIn(pixelValidIn),
        .newLine(newLine), .newScreen(newScreen), .cfgWe(cfgWe), .cfgAddr(cfgAddr),
        .cfgData(cfgData), .pixelOut(pixelOut), .pixelValidOut(pixelValidOut),
        .matchOut(matchOut), .matchCount(matchCount), .bboxXMin(bboxXMin),
        .bboxXMax(bboxXMax), .bboxYMin(bboxYMin), .bboxYMax(bboxYMax), .statsValid(statsValid)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fails  = 0;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    typedef struct {
        bit v; int pix; bit m; bit sv;
        int cnt; int xmin; int xmax; int ymin; int ymax;
    } exp_t;
    exp_t q[$];

    int m_min, m_max, m_mode, m_x, m_y, m_seen;
    int a_cnt, a_xmin, a_xmax, a_ymin, a_ymax;
    int s_cnt, s_xmin, s_xmax, s_ymin, s_ymax;

    function automatic bit in_win(int p, int lo, int hi);
        int r, g, b;
        r = (p >> 11) & 31; g = (p >> 5) & 63; b = p & 31;
        return r >= ((lo >> 11) & 31) && r <= ((hi >> 11) & 31) &&
               g >= ((lo >> 5) & 63)  && g <= ((hi >> 5) & 63)  &&
               b >= (lo & 31)         && b <= (hi & 31);
    endfunction

    function automatic int imin(int a, int b); return a < b ? a : b; endfunction
    function automatic int imax(int a, int b); return a > b ? a : b; endfunction

    task automatic acc_init();
        a_cnt = 0; a_xmin = 2047; a_xmax = 0; a_ymin = 1023; a_ymax = 0;
    endtask

    task automatic model_step(input bit v, input int p, input bit nl, input bit ns);
        exp_t e;
        e.v = v; e.pix = 0; e.m = 0; e.sv = 0;
        if (v) begin
            m_x = (nl || ns) ? 0 : imin(m_x + 1, 2047);
            if (ns)      m_y = 0;
            else if (nl) m_y = imin(m_y + 1, 1023);
            e.m = in_win(p, m_min, m_max);
            case (m_mode)
                0: e.pix = p;
                1: e.pix = e.m ? 'h07E0 : p;
                2: e.pix = e.m ? 'h07E0 : 0;
                default: e.pix = e.m ? p : 0;
            endcase
            if (ns) begin
                if (m_seen) begin
                    s_cnt = a_cnt; s_xmin = a_xmin; s_xmax = a_xmax; s_ymin = a_ymin; s_ymax = a_ymax;
                    e.sv = 1;
                end
                acc_init();
                m_seen = 1;
            end
            if (e.m) begin
                a_cnt = imin(a_cnt + 1, (1 << 20) - 1);
                a_xmin = imin(a_xmin, m_x); a_xmax = imax(a_xmax, m_x);
                a_ymin = imin(a_ymin, m_y); a_ymax = imax(a_ymax, m_y);
            end
        end
        e.cnt = s_cnt; e.xmin = s_xmin; e.xmax = s_xmax; e.ymin = s_ymin; e.ymax = s_ymax;
        q.push_back(e);
    endtask

    task automatic model_cfg(input int a, input int d);
        if (a == 0) m_min = d;
        else if (a == 1) m_max = d;
        else if (a == 2) m_mode = d & 3;
    endtask

    task automatic model_reset();
        m_min = 'hC018; m_max = 'hF9FF; m_mode = 1; m_x = 0; m_y = 0; m_seen = 0;
        acc_init();
        s_cnt = 0; s_xmin = 2047; s_xmax = 0; s_ymin = 1023; s_ymax = 0;
        q.delete();
        model_step(0, 0, 0, 0);
        model_step(0, 0, 0, 0);
    endtask

    task automatic check_front();
        exp_t e;
        e = q.pop_front();
        check_eq("pixelValidOut", pixelValidOut, e.v);
        if (e.v) begin
            check_eq("pixelOut", pixelOut, e.pix);
            check_eq("matchOut", matchOut, e.m);
        end
        check_eq("statsValid", statsValid, e.sv);
        check_eq("matchCount", matchCount, e.cnt);
        check_eq("bboxXMin", bboxXMin, e.xmin);
        check_eq("bboxXMax", bboxXMax, e.xmax);
        check_eq("bboxYMin", bboxYMin, e.ymin);
        check_eq("bboxYMax", bboxYMax, e.ymax);
    endtask

    task automatic drv(input bit v, input logic [15:0] p, input bit nl = 0, input bit ns = 0,
                       input bit we = 0, input logic [1:0] a = 0, input logic [15:0] d = 0);
        @(negedge clock);
        check_front();
        pixelIn = p; pixelValidIn = v; newLine = nl; newScreen = ns;
        cfgWe = we; cfgAddr = a; cfgData = d;
        model_step(v, int'(p), nl, ns);
        if (we) model_cfg(int'(a), int'(d));
    endtask

    task automatic cfg(input logic [1:0] a, input logic [15:0] d);
        drv(0, 16'h0, 0, 0, 1, a, d);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drv(0, 16'h0);
    endtask

    task automatic do_reset();
        @(negedge clock);
        #2;
        reset = 1'b1;
        pixelValidIn = 0; newLine = 0; newScreen = 0; cfgWe = 0; pixelIn = 0;
        #1;
        check_eq("rst pixelOut", pixelOut, 0);
        check_eq("rst pixelValidOut", pixelValidOut, 0);
        check_eq("rst matchOut", matchOut, 0);
        check_eq("rst statsValid", statsValid, 0);
        check_eq("rst matchCount", matchCount, 0);
        check_eq("rst bboxXMin", bboxXMin, 'h7FF);
        check_eq("rst bboxXMax", bboxXMax, 0);
        check_eq("rst bboxYMin", bboxYMin, 'h3FF);
        check_eq("rst bboxYMax", bboxYMax, 0);
        model_reset();
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic send_frame(input bit with_hits);
        for (int y = 0; y < 4; y++)
            for (int x = 0; x < 8; x++) begin
                bit h;
                h = with_hits && ((x == 2 && y == 1) || (x == 5 && y == 3) || (x == 3 && y == 2));
                drv(1, h ? 16'hF81F : 16'h1234, x == 0, x == 0 && y == 0);
            end
    endtask

    initial begin
        int lo_tab[5];
        lo_tab = '{'hC018, 'hF9FF, 'h0000, 'hFFFF, 'h8000};
        repeat (2) @(posedge clock);
        do_reset();

        drv(1, 16'hF81F); drv(1, 16'h001F); idle(3);

        cfg(2, 16'd0); drv(1, 16'hF81F); drv(1, 16'h1234);
        cfg(2, 16'd2); drv(1, 16'hF81F); drv(1, 16'h1234);
        cfg(2, 16'd3); drv(1, 16'hF81F); drv(1, 16'h1234);
        idle(2);

        cfg(2, 16'd1); cfg(0, 16'hF81F); cfg(1, 16'hF81F);
        drv(1, 16'hF81F); drv(1, 16'hF81E); drv(1, 16'hF83F);
        cfg(0, 16'hFFFF); cfg(1, 16'h0000);
        drv(1, 16'hF81F); drv(1, 16'h0000); drv(1, 16'hFFFF);
        idle(3);

        do_reset();
        send_frame(1);
        send_frame(0);
        drv(1, 16'h1234, 1, 1);
        idle(3);

        drv(1, 16'hF81F, 0, 0, 1, 2'd1, 16'h0000);
        drv(1, 16'hF81F);
        cfg(1, 16'hF9FF);
        idle(2);

        do_reset();
        drv(1, 16'hF81F, 1, 1);
        for (int i = 0; i < 5; i++) drv(1, 16'hF81F);
        drv(1, 16'h1234, 1, 1);
        for (int i = 0; i < 10; i++) drv(1, 16'hF81F, i == 4);
        idle(2);
        do_reset();
        drv(1, 16'hF81F, 1, 1);
        drv(1, 16'hF81F); drv(1, 16'h0000, 1, 0);
        drv(1, 16'h1234, 1, 1);
        idle(3);

        for (int i = 0; i < 3000; i++) begin
            bit v, nl, ns, we;
            logic [15:0] p, d;
            logic [1:0] a;
            v  = ($urandom_range(0, 3) != 0);
            ns = ($urandom_range(0, 150) == 0);
            nl = ($urandom_range(0, 12) == 0);
            if ($urandom_range(0, 1) == 0)
                p = {5'($urandom_range(20, 31)), 6'($urandom_range(0, 20)), 5'($urandom_range(20, 31))};
            else
                p = 16'($urandom);
            we = ($urandom_range(0, 60) == 0);
            a  = 2'($urandom_range(0, 3));
            d  = (a == 2'd2) ? 16'($urandom_range(0, 3)) :
                 ($urandom_range(0, 1) == 0) ? 16'(lo_tab[$urandom_range(0, 4)]) : 16'($urandom);
            drv(v, p, nl, ns, we, a, d);
        end
        idle(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
